// File: rtl/dwc_scheduler_pkg.sv
// Shared types and constants for the depthwise-convolution strip scheduler.
package dwc_scheduler_pkg;

  // Kernel size; the strip unit is built around a fixed 3x3 window.
  localparam int K = 3;
  // Output rows produced per strip, and input rows needed to produce them.
  localparam int STRIP_OUT_ROWS = 4;
  localparam int STRIP_IN_ROWS  = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WAIT,
    ST_STREAM,
    ST_DRAIN,
    ST_NEXT,
    ST_FIN
  } state_t;

endpackage

// File: rtl/dwc_sched_delay.sv
// Valid delay line matching the input-memory read latency.
module dwc_sched_delay #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [LAT-1:0] stage_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        // First tap captures the read strobe.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) stage_reg[gi] <= 1'b0;
          else     stage_reg[gi] <= din;
        end
      end else begin : g_rest
        // Later taps shift the strobe one cycle further.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) stage_reg[gi] <= 1'b0;
          else     stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign dout = stage_reg[LAT-1];

endmodule

// File: rtl/dwc_scheduler.sv
// Walks a feature map in 4-output-row strips, issuing column reads to the
// strip unit and counting its results to detect strip completion.
module dwc_scheduler
  import dwc_scheduler_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIM_W  = 7,
  parameter int RD_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DIM_W-1:0]            cfg_w,
  input  logic [DIM_W-1:0]            cfg_h,
  input  logic [K*K*DATA_W-1:0]       w_in,
  input  logic                        strip_ready,
  input  logic                        dwc_out_valid0,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        rd_en,
  output logic [DIM_W-1:0]            rd_row,
  output logic [DIM_W-1:0]            rd_col,
  output logic [STRIP_IN_ROWS-1:0]    rd_row_mask,
  output logic                        dwc_in_valid,
  output logic [K*DATA_W-1:0]         w_col0,
  output logic [K*DATA_W-1:0]         w_col1,
  output logic [K*DATA_W-1:0]         w_col2,
  output logic [DIM_W-1:0]            out_row,
  output logic [STRIP_OUT_ROWS-1:0]   out_row_mask,
  output logic                        strip_done
);

  state_t                state_reg, state_next;
  logic [DIM_W-1:0]      cfg_w_reg, cfg_w_next;
  logic [DIM_W-1:0]      cfg_h_reg, cfg_h_next;
  logic [K*K*DATA_W-1:0] w_reg, w_next;
  logic [DIM_W-1:0]      r_reg, r_next;
  logic [DIM_W-1:0]      c_reg, c_next;
  logic [DIM_W-1:0]      cnt_reg, cnt_next;

  logic                  cfg_ok;
  logic [DIM_W-1:0]      h_out;
  logic [DIM_W-1:0]      w_out;
  logic [DIM_W:0]        r_plus_step;
  logic [DIM_W-1:0]      cnt_inc;
  logic                  strip_complete;
  logic [K*DATA_W-1:0]   w_col_arr [K];

  // Sizes below K can't hold a single window; h_out/w_out are only meaningful when cfg_ok.
  assign cfg_ok         = (cfg_w_reg >= DIM_W'(K)) && (cfg_h_reg >= DIM_W'(K));
  assign h_out          = cfg_h_reg - DIM_W'(K - 1);
  assign w_out          = cfg_w_reg - DIM_W'(K - 1);
  assign r_plus_step    = {1'b0, r_reg} + (DIM_W+1)'(STRIP_OUT_ROWS);
  assign cnt_inc        = cnt_reg + {{(DIM_W-1){1'b0}}, dwc_out_valid0};
  // Completion uses the incremented count so it fires on the cycle the last pulse arrives.
  assign strip_complete = (state_reg == ST_DRAIN) && (cnt_inc >= w_out);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cfg_w_reg <= '0;
      cfg_h_reg <= '0;
      w_reg     <= '0;
      r_reg     <= '0;
      c_reg     <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cfg_w_reg <= cfg_w_next;
      cfg_h_reg <= cfg_h_next;
      w_reg     <= w_next;
      r_reg     <= r_next;
      c_reg     <= c_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_next = state_reg;
    cfg_w_next = cfg_w_reg;
    cfg_h_next = cfg_h_reg;
    w_next     = w_reg;
    r_next     = r_reg;
    c_next     = c_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          cfg_w_next = cfg_w;
          cfg_h_next = cfg_h;
          w_next     = w_in;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!cfg_ok) begin
          state_next = ST_IDLE;
        end else begin
          r_next     = '0;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        c_next   = '0;
        cnt_next = '0;
        if (strip_ready) state_next = ST_STREAM;
      end
      ST_STREAM: begin
        cnt_next = cnt_inc;
        if (c_reg == cfg_w_reg - DIM_W'(1)) begin
          c_next     = '0;
          state_next = ST_DRAIN;
        end else begin
          c_next = c_reg + DIM_W'(1);
        end
      end
      ST_DRAIN: begin
        cnt_next = cnt_inc;
        if (strip_complete) state_next = ST_NEXT;
      end
      ST_NEXT: begin
        r_next = r_plus_step[DIM_W-1:0];
        if (r_plus_step >= {1'b0, h_out}) state_next = ST_FIN;
        else                              state_next = ST_WAIT;
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy       = (state_reg != ST_IDLE);
  assign done       = (state_reg == ST_FIN);
  assign err        = (state_reg == ST_CHECK) && !cfg_ok;
  assign rd_en      = (state_reg == ST_STREAM);
  assign rd_row     = r_reg;
  assign rd_col     = c_reg;
  assign out_row    = r_reg;
  assign strip_done = strip_complete;

  genvar gi;
  generate
    // Input row i of the strip exists while it lies above the map bottom.
    for (gi = 0; gi < STRIP_IN_ROWS; gi++) begin : g_in_mask
      assign rd_row_mask[gi] = cfg_ok &&
        (({1'b0, r_reg} + (DIM_W+1)'(gi)) < {1'b0, cfg_h_reg});
    end
    // Output row j of the strip is real while it lies above the output bottom.
    for (gi = 0; gi < STRIP_OUT_ROWS; gi++) begin : g_out_mask
      assign out_row_mask[gi] = cfg_ok &&
        (({1'b0, r_reg} + (DIM_W+1)'(gi)) < {1'b0, h_out});
    end
    // Kernel column c is the contiguous 3-weight slice for that column.
    for (gi = 0; gi < K; gi++) begin : g_wcol
      assign w_col_arr[gi] = w_reg[gi*K*DATA_W +: K*DATA_W];
    end
  endgenerate

  assign w_col0 = w_col_arr[0];
  assign w_col1 = w_col_arr[1];
  assign w_col2 = w_col_arr[2];

  dwc_sched_delay #(
    .LAT (RD_LAT)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (rd_en),
    .dout (dwc_in_valid)
  );

endmodule
